// File: rtl/luhn_gen.sv
// luhn_gen: Luhn check-digit generator; collects payload, emits check + reversed payload.
// Optional LUHN_GEN_RANGE_CHECK_EN: digits > 9 trap into ERROR instead of being summed.
module luhn_gen #(
  parameter int NUM_DIGITS = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       clr,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] check_digit,
  output logic       check_valid,
  output logic [3:0] out_digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       error
);

  localparam int PL = NUM_DIGITS - 1;
  localparam int KW = $clog2(NUM_DIGITS);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_DIGITS - 2);
  localparam logic [KW-1:0] I_LAST = KW'(NUM_DIGITS - 1);
  localparam logic PAR = 1'(PL % 2);

  typedef enum logic [2:0] {
    COLLECT,
    COMPUTE,
    EMIT,
    DONE,
    ERROR
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [KW-1:0] idx;
  logic [3:0]    sum;
  logic [3:0]    mem [PL];

  logic          take;
  logic          dbl;
  logic          bad;
  logic [4:0]    d5;
  logic [4:0]    dv;
  logic [3:0]    acc;
  logic [3:0]    chk;

  function automatic logic [3:0] mod10(input logic [5:0] t);
    if (t >= 6'd30) return 4'(t - 6'd30);
    else if (t >= 6'd20) return 4'(t - 6'd20);
    else if (t >= 6'd10) return 4'(t - 6'd10);
    else return 4'(t);
  endfunction

  // Weight the incoming digit by its position from the check digit.
  always_comb begin
    take = in_valid && in_ready;
    dbl  = (k[0] != PAR);
    d5   = dbl ? {in_digit, 1'b0} : {1'b0, in_digit};
    dv   = (d5 > 5'd9) ? d5 - 5'd9 : d5;
    acc  = mod10(6'(dv) + 6'(sum));
    chk  = (sum == 4'd0) ? 4'd0 : 4'd10 - sum;
`ifdef LUHN_GEN_RANGE_CHECK_EN
    bad  = (in_digit > 4'd9);
`else
    bad  = 1'b0;
`endif
  end

  // Payload store, written in arrival order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < PL; i++) mem[i] <= '0;
    end else if (!clr && state == COLLECT && take && !bad) begin
      mem[k] <= in_digit;
    end
  end

  // Control FSM with registered handshake and output signals.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= COLLECT;
      k           <= '0;
      idx         <= '0;
      sum         <= '0;
      check_digit <= '0;
      check_valid <= 1'b0;
      out_digit   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      error       <= 1'b0;
      in_ready    <= 1'b1;
    end else if (clr) begin
      state       <= COLLECT;
      k           <= '0;
      idx         <= '0;
      sum         <= '0;
      check_digit <= '0;
      check_valid <= 1'b0;
      out_digit   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      error       <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      unique case (state)
        COLLECT: begin
          if (take) begin
            if (bad) begin
              state    <= ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              sum <= acc;
              k   <= k + 1'b1;
              if (k == K_LAST) begin
                state    <= COMPUTE;
                in_ready <= 1'b0;
              end
            end
          end
        end
        COMPUTE: begin
          check_digit <= chk;
          check_valid <= 1'b1;
          out_digit   <= chk;
          out_valid   <= 1'b1;
          out_last    <= 1'b0;
          idx         <= '0;
          state       <= EMIT;
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (idx == I_LAST) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_digit <= '0;
            end else begin
              idx       <= idx + 1'b1;
              out_digit <= mem[K_LAST - idx];
              out_last  <= (idx == K_LAST);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_luhn_gen.sv
// tb_luhn_gen: directed checks for luhn_gen.
// Range-error steps run only when LUHN_GEN_RANGE_CHECK_EN is defined.
module tb_luhn_gen;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] in_digit;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] check_digit;
  logic       check_valid;
  logic [3:0] out_digit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       error;

  int n_chk;
  int n_fail;

  logic [3:0] pay    [15];
  logic [3:0] stream [16];

  luhn_gen #(.NUM_DIGITS(16)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .clr        (clr),
    .in_digit   (in_digit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .check_digit(check_digit),
    .check_valid(check_valid),
    .out_digit  (out_digit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed();
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_digit = pay[i];
      step();
    end
    in_valid = 1'b0;
    in_digit = 4'd0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic load_a();
    pay = '{4'd4, 4'd5, 4'd3, 4'd9, 4'd1, 4'd4, 4'd8, 4'd8,
            4'd0, 4'd3, 4'd4, 4'd3, 4'd6, 4'd4, 4'd6};
  endtask

  initial begin
    int j;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    out_ready = 1'b0;
    stream = '{4'd7, 4'd6, 4'd4, 4'd6, 4'd3, 4'd4, 4'd3, 4'd0,
               4'd8, 4'd8, 4'd4, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_check_digit", 8'(check_digit), 8'd0);
    chk("rst_check_valid", 8'(check_valid), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_last", 8'(out_last), 8'd0);
    chk("rst_error", 8'(error), 8'd0);
    chk("rst_out_digit", 8'(out_digit), 8'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 8'(in_ready), 8'd1);

    // main example, out_ready held high
    out_ready = 1'b1;
    load_a();
    feed();
    chk("a_cv_early", 8'(check_valid), 8'd0);
    chk("a_in_ready_low", 8'(in_ready), 8'd0);
    step();
    chk("a_cv", 8'(check_valid), 8'd1);
    chk("a_check_digit", 8'(check_digit), 8'd7);
    for (int i = 0; i < 16; i++) begin
      chk("a_out_valid", 8'(out_valid), 8'd1);
      chk("a_out_digit", 8'(out_digit), 8'(stream[i]));
      chk("a_out_last", 8'(out_last), (i == 15) ? 8'd1 : 8'd0);
      step();
    end
    chk("a_done_out_valid", 8'(out_valid), 8'd0);
    chk("a_done_in_ready", 8'(in_ready), 8'd0);
    chk("a_done_cv", 8'(check_valid), 8'd1);
    chk("a_done_cd", 8'(check_digit), 8'd7);
    step();
    chk("a_done_hold_cv", 8'(check_valid), 8'd1);
    do_clr();
    chk("clr_in_ready", 8'(in_ready), 8'd1);
    chk("clr_cv", 8'(check_valid), 8'd0);

    // fourteen zeros then one
    for (int i = 0; i < 15; i++) pay[i] = 4'd0;
    pay[14] = 4'd1;
    feed();
    step();
    chk("b_cv", 8'(check_valid), 8'd1);
    chk("b_check_digit", 8'(check_digit), 8'd8);
    chk("b_first_out", 8'(out_digit), 8'd8);
    do_clr();
    chk("b_clr_out_valid", 8'(out_valid), 8'd0);

    // all zeros
    pay[14] = 4'd0;
    feed();
    step();
    chk("z_check_digit", 8'(check_digit), 8'd0);
    do_clr();

    // stalled output stream
    load_a();
    feed();
    step();
    j = 0;
    for (int c = 0; c < 64 && j < 16; c++) begin
      out_ready = (c % 2 == 0);
      chk("c_out_valid", 8'(out_valid), 8'd1);
      chk("c_out_digit", 8'(out_digit), 8'(stream[j]));
      chk("c_out_last", 8'(out_last), (j == 15) ? 8'd1 : 8'd0);
      step();
      if (out_ready) j++;
    end
    chk("c_all_beats", 8'(j), 8'd16);
    chk("c_done_out_valid", 8'(out_valid), 8'd0);
    out_ready = 1'b1;
    do_clr();

    // clr during a transfer after seven digits
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_digit = 4'd9;
      step();
    end
    in_valid = 1'b1;
    in_digit = 4'd5;
    clr = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("d_in_ready", 8'(in_ready), 8'd1);
    chk("d_cv", 8'(check_valid), 8'd0);
    load_a();
    feed();
    chk("d_cv_early", 8'(check_valid), 8'd0);
    step();
    chk("d_cv", 8'(check_valid), 8'd1);
    chk("d_check_digit", 8'(check_digit), 8'd7);
    do_clr();

    // reset during EMIT
    load_a();
    feed();
    step();
    step();
    step();
    chk("e_mid_out_digit", 8'(out_digit), 8'(stream[2]));
    rst_n = 1'b0;
    #1;
    chk("e_rst_out_valid", 8'(out_valid), 8'd0);
    chk("e_rst_cv", 8'(check_valid), 8'd0);
    chk("e_rst_out_last", 8'(out_last), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("e_in_ready", 8'(in_ready), 8'd1);
    step();
    chk("e_no_beats", 8'(out_valid), 8'd0);

`ifdef LUHN_GEN_RANGE_CHECK_EN
    // out-of-range digit on the third transfer
    do_clr();
    in_valid = 1'b1;
    in_digit = 4'd1;
    step();
    step();
    in_digit = 4'd12;
    step();
    chk("r_error", 8'(error), 8'd1);
    chk("r_in_ready", 8'(in_ready), 8'd0);
    in_digit = 4'd2;
    step();
    step();
    chk("r_error_hold", 8'(error), 8'd1);
    chk("r_in_ready_hold", 8'(in_ready), 8'd0);
    chk("r_cv", 8'(check_valid), 8'd0);
    chk("r_out_valid", 8'(out_valid), 8'd0);
    in_valid = 1'b0;
    do_clr();
    chk("r_clr_error", 8'(error), 8'd0);
    chk("r_clr_in_ready", 8'(in_ready), 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
